// File: rtl/lsu_pkg.sv
// Shared types and helpers for the byte-serial load/store unit: FSM states,
// RV32 load func3 codes and the func3 -> byte-count mapping.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Size is carried by func3[1:0]; the unused codes fall through to word.
    function automatic logic [2:0] byte_count(input logic [2:0] func3);
        case (func3[1:0])
            2'b00:   byte_count = 3'd1;
            2'b01:   byte_count = 3'd2;
            default: byte_count = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Combinational load-data extension: picks the low byte/half/word of the
// assembled accumulator and sign- or zero-extends it according to func3.
module lsu_extend
    import lsu_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [31:0] acc,
    output logic [31:0] rdata
);

    always_comb begin
        rdata = acc;
        case (func3)
            F3_LB:   rdata = {{24{acc[7]}}, acc[7:0]};
            F3_LH:   rdata = {{16{acc[15]}}, acc[15:0]};
            F3_LBU:  rdata = {24'd0, acc[7:0]};
            F3_LHU:  rdata = {16'd0, acc[15:0]};
            default: rdata = acc;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte-serial, big-endian load/store sequencer for a byte-wide data RAM.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned h/w accesses return rsp_err without touching memory.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int WA  = 32,
    parameter int WAM = 20,
    parameter int WD  = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic           req_write,
    input  logic [2:0]     req_func3,
    input  logic [WA-1:0]  req_addr,
    input  logic [WD-1:0]  req_wdata,
    output logic           rsp_valid,
    output logic [WD-1:0]  rsp_rdata,
    output logic           rsp_err,
    output logic [WAM-1:0] mem_addr,
    output logic           mem_we,
    output logic [7:0]     mem_wbyte,
    input  logic [7:0]     mem_rbyte
);

    lsu_state_t     state_q, state_d;
    logic [WAM-1:0] base_q, base_d;
    logic [2:0]     func3_q, func3_d;
    logic           write_q, write_d;
    logic [WD-1:0]  wdata_q, wdata_d;
    logic [1:0]     idx_q, idx_d;
    logic [31:0]    acc_q, acc_d;
    logic           err_q, err_d;

    logic [2:0]     n_bytes;
    logic [1:0]     last_idx;
    logic [1:0]     byte_sel;
    logic [2:0]     req_n;
    logic           misaligned;
    logic [31:0]    ext_rdata;

    // Upper core-address bits are deliberately dropped by the memory port.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[WA-1:WAM];

    assign req_n = byte_count(req_func3);

`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned = ((req_n == 3'd2) && req_addr[0]) ||
                        ((req_n == 3'd4) && (req_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign n_bytes  = byte_count(func3_q);
    assign last_idx = 2'(n_bytes - 3'd1);
    // Big-endian: the first byte cycle carries the most significant byte.
    assign byte_sel = last_idx - idx_q;

    lsu_extend u_extend (
        .func3 (func3_q),
        .acc   (acc_q),
        .rdata (ext_rdata)
    );

    assign req_ready = (state_q == IDLE);

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        func3_d   = func3_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        err_d     = err_q;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wbyte = 8'd0;
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    base_d  = req_addr[WAM-1:0];
                    func3_d = req_func3;
                    write_d = req_write;
                    wdata_d = req_wdata;
                    idx_d   = 2'd0;
                    acc_d   = 32'd0;
                    err_d   = misaligned;
                    state_d = misaligned ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                mem_addr = base_q + WAM'(idx_q);
                mem_we   = write_q;
                if (write_q) begin
                    mem_wbyte = 8'(wdata_q >> {byte_sel, 3'b000});
                end else begin
                    acc_d = {acc_q[23:0], mem_rbyte};
                end
                if (idx_q == last_idx) begin
                    state_d = RESP;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                rsp_rdata = (write_q || err_q) ? '0 : WD'(ext_rdata);
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            func3_q <= 3'd0;
            write_q <= 1'b0;
            wdata_q <= '0;
            idx_q   <= 2'd0;
            acc_q   <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            func3_q <= func3_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte-addressed RAM plus a
// reference memory image and arithmetic load/store model.
module tb_load_store_unit;

    localparam int WA  = 32;
    localparam int WAM = 20;
    localparam int WD  = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           req_valid;
    logic           req_ready;
    logic           req_write;
    logic [2:0]     req_func3;
    logic [WA-1:0]  req_addr;
    logic [WD-1:0]  req_wdata;
    logic           rsp_valid;
    logic [WD-1:0]  rsp_rdata;
    logic           rsp_err;
    logic [WAM-1:0] mem_addr;
    logic           mem_we;
    logic [7:0]     mem_wbyte;
    logic [7:0]     mem_rbyte;

    int errors = 0;
    int checks = 0;

    bit [7:0] ram     [0:(1<<WAM)-1];
    bit [7:0] ref_ram [0:(1<<WAM)-1];

    always #5 clk = ~clk;

    assign mem_rbyte = ram[mem_addr];
    always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wbyte;

    load_store_unit #(.WA(WA), .WAM(WAM), .WD(WD)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wbyte(mem_wbyte),
        .mem_rbyte(mem_rbyte)
    );

    function automatic int nbytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit is_trap(input logic [2:0] f3, input logic [31:0] addr);
`ifdef LSU_MISALIGN_TRAP_EN
        int n = nbytes(f3);
        return (addr % n) != 0;
`else
        return 1'b0;
`endif
    endfunction

    // Big-endian assembly from the reference image, then extension by plain arithmetic.
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
        int n = nbytes(f3);
        logic [31:0] v = 0;
        for (int i = 0; i < n; i++) v = v * 256 + 32'(ref_ram[(addr + i) % (1 << WAM)]);
        if (f3 == 3'b000 && v >= 128)   v = v - 256;
        if (f3 == 3'b001 && v >= 32768) v = v - 65536;
        return v;
    endfunction

    task automatic run_txn(input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, output logic [31:0] got);
        int n = nbytes(f3);
        bit trap = is_trap(f3, addr);
        int lat = trap ? 1 : n + 1;
        logic [31:0] exp_rd = (wr || trap) ? 32'd0 : model_load(f3, addr);
        logic [WAM-1:0] ea;
        logic [7:0] eb;
        got = 32'd0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL ready_before_req: got %b want 1", req_ready); end
        req_valid = 1'b1; req_write = wr; req_func3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1;
        for (int k = 1; k <= lat; k++) begin
            // Garbage request held while busy must be ignored.
            req_valid = (k < lat); req_write = ~wr; req_func3 = 3'($urandom);
            req_addr = $urandom; req_wdata = $urandom;
            @(negedge clk);
            if (k < lat) begin
                ea = WAM'((addr + k - 1) % (1 << WAM));
                eb = 8'(wd >> (8 * (n - k)));
                checks++;
                if (mem_we !== wr) begin errors++; $display("FAIL mem_we cyc%0d: got %b want %b", k, mem_we, wr); end
                checks++;
                if (mem_addr !== ea) begin errors++; $display("FAIL mem_addr cyc%0d: got %h want %h", k, mem_addr, ea); end
                if (wr) begin
                    checks++;
                    if (mem_wbyte !== eb) begin errors++; $display("FAIL mem_wbyte cyc%0d: got %h want %h", k, mem_wbyte, eb); end
                    ref_ram[ea] = eb;
                end
                checks++;
                if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
                    errors++; $display("FAIL busy cyc%0d: rsp_valid=%b req_ready=%b want 0/0", k, rsp_valid, req_ready);
                end
            end else begin
                got = rsp_rdata;
                checks++;
                if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rsp_valid latency %0d: got %b want 1", lat, rsp_valid); end
                checks++;
                if (rsp_rdata !== exp_rd) begin errors++; $display("FAIL rsp_rdata: got %h want %h", rsp_rdata, exp_rd); end
                checks++;
                if (rsp_err !== trap) begin errors++; $display("FAIL rsp_err: got %b want %b", rsp_err, trap); end
                checks++;
                if (mem_we !== 1'b0) begin errors++; $display("FAIL mem_we_in_resp: got %b want 0", mem_we); end
            end
        end
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL after_resp: rsp_valid=%b req_ready=%b want 0/1", rsp_valid, req_ready);
        end
        if (wr) begin
            for (int i = 0; i < n; i++) begin
                ea = WAM'((addr + i) % (1 << WAM));
                checks++;
                if (ram[ea] !== ref_ram[ea]) begin errors++; $display("FAIL ram[%h]: got %h want %h", ea, ram[ea], ref_ram[ea]); end
            end
        end
        $display("txn %s f3=%0d addr=%h wdata=%h rdata=%h err=%0b lat=%0d",
                 wr ? "st" : "ld", f3, addr, wd, got, trap, lat);
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_func3 = 3'd0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== '0 || rsp_err !== 1'b0 || mem_we !== 1'b0 ||
            mem_addr !== '0 || mem_wbyte !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs: rsp_valid=%b rdata=%h err=%b we=%b addr=%h wbyte=%h want all 0",
                     rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_wbyte);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        $display("txn reset released");
    endtask

    task automatic test_store_word();
        logic [31:0] rd;
        logic [31:0] want;
        run_txn(1'b1, 3'b010, 32'h0001_0000, 32'h1234_5678, rd);
        want = {ram[20'h10000], ram[20'h10001], ram[20'h10002], ram[20'h10003]};
        checks++;
        if (want !== 32'h1234_5678) begin errors++; $display("FAIL sw_bytes: got %h want 12345678", want); end
    endtask

    task automatic test_load_byte();
        logic [31:0] rd;
        run_txn(1'b1, 3'b000, 32'h0001_0003, 32'h0000_0080, rd);
        run_txn(1'b0, 3'b000, 32'h0001_0003, 32'h0, rd);
        checks++;
        if (rd !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb: got %h want ffffff80", rd); end
        run_txn(1'b0, 3'b100, 32'h0001_0003, 32'h0, rd);
        checks++;
        if (rd !== 32'h0000_0080) begin errors++; $display("FAIL lbu: got %h want 00000080", rd); end
    endtask

    task automatic test_load_half();
        logic [31:0] rd;
        run_txn(1'b1, 3'b001, 32'h0001_0000, 32'hDEAD_9ABC, rd);
        run_txn(1'b0, 3'b001, 32'h0001_0000, 32'h0, rd);
        checks++;
        if (rd !== 32'hFFFF_9ABC) begin errors++; $display("FAIL lh: got %h want ffff9abc", rd); end
        run_txn(1'b0, 3'b101, 32'h0001_0000, 32'h0, rd);
        checks++;
        if (rd !== 32'h0000_9ABC) begin errors++; $display("FAIL lhu: got %h want 00009abc", rd); end
    endtask

    task automatic test_wrap();
        logic [31:0] rd;
        logic [31:0] want;
`ifdef LSU_MISALIGN_TRAP_EN
        want = 32'h0;
`else
        want = 32'hCAFE_F00D;
`endif
        // Upper core-address bits must be dropped by the truncation to the memory width.
        run_txn(1'b1, 3'b010, 32'hABCF_FFFE, 32'hCAFE_F00D, rd);
        run_txn(1'b0, 3'b010, 32'h000F_FFFE, 32'h0, rd);
        checks++;
        if (rd !== want) begin errors++; $display("FAIL lw_wrap: got %h want %h", rd, want); end
    endtask

    task automatic test_misalign();
        logic [31:0] rd;
        logic [31:0] want;
`ifdef LSU_MISALIGN_TRAP_EN
        want = 32'h0;
`else
        want = 32'h5680_0000;
`endif
        run_txn(1'b0, 3'b010, 32'h0001_0002, 32'h0, rd);
        checks++;
        if (rd !== want) begin errors++; $display("FAIL lw_misaligned: got %h want %h", rd, want); end
    endtask

    task automatic test_reset_mid();
        logic [WAM-1:0] a;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_func3 = 3'b010;
        req_addr = 32'h0001_0020; req_wdata = 32'hA1B2_C3D4;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (mem_we !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL mid_reset_outputs: we=%b rsp_valid=%b want 0/0", mem_we, rsp_valid);
        end
        ref_ram[20'h10020] = 8'hA1;
        ref_ram[20'h10021] = 8'hB2;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_rsp cyc%0d: got %b want 0", c, rsp_valid); end
        end
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
                errors++; $display("FAIL post_reset cyc%0d: rsp_valid=%b ready=%b want 0/1", c, rsp_valid, req_ready);
            end
        end
        for (int i = 0; i < 4; i++) begin
            a = WAM'(32'h10020 + i);
            checks++;
            if (ram[a] !== ref_ram[a]) begin errors++; $display("FAIL mid_reset_ram[%h]: got %h want %h", a, ram[a], ref_ram[a]); end
        end
        $display("txn st aborted by reset addr=00010020 bytes_written=2");
    endtask

    task automatic test_random();
        logic [31:0] rd;
        logic [31:0] addr;
        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 3) == 0) addr = {12'($urandom), 20'hFFFF8 + 20'($urandom_range(0, 7))};
            else                           addr = {12'($urandom), 20'h10000 + 20'($urandom_range(0, 63))};
            run_txn(1'($urandom), 3'($urandom), addr, $urandom, rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        run_txn(1'b1, 3'b010, 32'h0001_0040, 32'h0102_0304, rd);
        run_txn(1'b0, 3'b010, 32'h0001_0040, 32'h0, rd);
        checks++;
        if (rd !== 32'h0102_0304) begin errors++; $display("FAIL b2b_lw: got %h want 01020304", rd); end
        run_txn(1'b0, 3'b000, 32'h0001_0041, 32'h0, rd);
        checks++;
        if (rd !== 32'h0000_0002) begin errors++; $display("FAIL b2b_lb: got %h want 00000002", rd); end
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_load_byte();
        test_load_half();
        test_wrap();
        test_misalign();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
